team_id_capture: RTL and testbench

Receives the team ID frame from the radio over a 3-wire serial link, validates it and presents a stable, latched 16-bit ID on `team_id_out`, which drives the `team_id_in` input of the memory-mapped team ID read peripheral. The block sits in the `mclk` domain beside the openMSP430 peripheral bus. It synchronizes the asynchronous radio pins and runs a small frame-parsing FSM. It also keeps a saturating error counter for debug.

---
 rtl/team_id_pkg.sv | 11 +
 rtl/team_id_sync2.sv | 14 +
 rtl/team_id_capture.sv | 75 +++++++
 tb/tb_team_id_capture.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/team_id_pkg.sv
// team_id_pkg: shared FSM state type and frame field constants for team ID capture
package team_id_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, ID, CHK, DRAIN} state_t;
  localparam int SYNC_LEN = 8;
  localparam int ID_LEN = 16;
  localparam int CHK_LEN = 8;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  function automatic logic [4:0] field_last(input state_t s);
    return s == ID ? 5'(ID_LEN - 1) : s == SYNC ? 5'(SYNC_LEN - 1) : 5'(CHK_LEN - 1);
  endfunction
endpackage

// File: rtl/team_id_sync2.sv
// team_id_sync2: 2-flop synchronizer with configurable reset level
module team_id_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, meta} <= {2{RST_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/team_id_capture.sv
// team_id_capture: parses radio team ID frames and latches the validated ID
module team_id_capture
  import team_id_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096,
  parameter logic [15:0] DEFAULT_ID  = 16'h0000
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        radio_sclk,
  input  logic        radio_sdata,
  input  logic        radio_cs_n,
  output logic [15:0] team_id_out,
  output logic        team_id_valid,
  output logic        frame_err,
  output logic [7:0]  err_count
);
  logic sclk_s, sdata_s, cs_n_s, sclk_d, cs_n_d;
  logic sclk_rise, cs_fall, last, active, tmo_hit, done, accept, bit_rej, abort;
  logic [15:0] sh, sh_n, shadow, tmo;
  logic [4:0] cnt;
  state_t state, state_n;
  team_id_sync2 #(.RST_VAL(1'b0)) u_sclk (.clk(mclk), .rst(puc_rst), .d(radio_sclk), .q(sclk_s));
  team_id_sync2 #(.RST_VAL(1'b0)) u_sdata (.clk(mclk), .rst(puc_rst), .d(radio_sdata), .q(sdata_s));
  team_id_sync2 #(.RST_VAL(1'b1)) u_cs_n (.clk(mclk), .rst(puc_rst), .d(radio_cs_n), .q(cs_n_s));
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall = cs_n_d & ~cs_n_s;
  assign sh_n = {sh[14:0], sdata_s};
  assign last = cnt == field_last(state);
  assign active = state inside {SYNC, ID, CHK};
  assign tmo_hit = (tmo == TIMEOUT_CYC) & ~sclk_rise;
  assign done = sclk_rise & last & (state == CHK);
  assign accept = done & (sh_n[7:0] == (shadow[15:8] ^ shadow[7:0]));
  assign bit_rej = (done & ~accept) | (sclk_rise & last & (state == SYNC) & (sh_n[7:0] != SYNC_BYTE));
  // a bit landing together with cs_n high is processed first; only a completed frame escapes the abort
  assign abort = active & (cs_n_s | tmo_hit) & ~done & ~bit_rej;
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else if (bit_rej | done) state_n = DRAIN;
    else if (state == IDLE && cs_fall) state_n = SYNC;
    else if (state == SYNC && sclk_rise && last) state_n = ID;
    else if (state == ID && sclk_rise && last) state_n = CHK;
    else if (state == DRAIN && cs_n_s) state_n = IDLE;
  end
  always_ff @(posedge mclk or posedge puc_rst)
    if (puc_rst) begin
      state <= IDLE;
      sclk_d <= 1'b0;
      cs_n_d <= 1'b1;
      sh <= '0;
      shadow <= '0;
      cnt <= '0;
      tmo <= '0;
      team_id_out <= DEFAULT_ID;
      team_id_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_n;
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
      frame_err <= bit_rej | abort;
      tmo <= (!active || sclk_rise) ? '0 : tmo + 1'b1;
      cnt <= (state_n != state) ? '0 : (sclk_rise && active) ? cnt + 1'b1 : cnt;
      if (sclk_rise && active) sh <= sh_n;
      if (state == ID && sclk_rise && last) shadow <= sh_n;
      if (accept) begin
        team_id_out <= shadow;
        team_id_valid <= 1'b1;
      end
      if ((bit_rej | abort) && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
endmodule

// File: tb/tb_team_id_capture.sv
// tb_team_id_capture: randomized frame-level bench with a behavioural reference model
module tb_team_id_capture;
  localparam logic [7:0] SB = 8'hA5;
  logic mclk = 0, puc_rst = 1, radio_sclk = 0, radio_sdata = 0, radio_cs_n = 1;
  logic [15:0] team_id_out;
  logic team_id_valid, frame_err;
  logic [7:0] err_count;
  int total = 0, passed = 0, pulses = 0, exp_pulses = 0, exp_err = 0;
  logic [15:0] exp_id = 16'h0000;
  logic exp_valid = 0;

  team_id_capture dut (
    .mclk(mclk), .puc_rst(puc_rst), .radio_sclk(radio_sclk), .radio_sdata(radio_sdata),
    .radio_cs_n(radio_cs_n), .team_id_out(team_id_out), .team_id_valid(team_id_valid),
    .frame_err(frame_err), .err_count(err_count)
  );

  always #5 mclk = ~mclk;
  always @(negedge mclk) if (frame_err) pulses++;

  function automatic logic [63:0] mk(input logic [7:0] s, input logic [15:0] id, input logic [7:0] c);
    return {s, id, c, 32'h0};
  endfunction

  // one cs_n window: valid only if it holds a full frame with correct sync and checksum
  task automatic model_window(input logic [63:0] b, input int n);
    logic [7:0] s, c;
    logic [15:0] id;
    s = b[63:56];
    id = b[55:40];
    c = b[39:32];
    if (n >= 32 && s == SB && c == (id[15:8] ^ id[7:0])) begin
      exp_id = id;
      exp_valid = 1;
    end else begin
      exp_pulses++;
      if (exp_err < 255) exp_err++;
    end
  endtask

  task automatic send_bits(input logic [63:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      radio_sdata = b[63-i];
      repeat (4) @(negedge mclk);
      radio_sclk = 1;
      repeat (4) @(negedge mclk);
      radio_sclk = 0;
    end
  endtask

  task automatic send_window(input logic [63:0] b, input int n, input int hold);
    radio_cs_n = 0;
    repeat (4) @(negedge mclk);
    send_bits(b, n);
    repeat (hold) @(negedge mclk);
    radio_cs_n = 1;
    repeat (8) @(negedge mclk);
    model_window(b, n);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge mclk);
    total++; if (team_id_out !== 16'h0000) $display("FAIL reset_id got %h exp 0000", team_id_out); else passed++;
    total++; if (team_id_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", team_id_valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b exp 0", frame_err); else passed++;
    total++; if (err_count !== 8'd0) $display("FAIL reset_errcnt got %0d exp 0", err_count); else passed++;
    puc_rst = 0;
    repeat (4) @(negedge mclk);
  endtask

  task automatic test_good;
    send_window(mk(SB, 16'h1234, 8'h26), 32, 4);
    total++; if (team_id_out !== 16'h1234) $display("FAIL good_id got %h exp 1234", team_id_out); else passed++;
    total++; if (team_id_valid !== 1'b1) $display("FAIL good_valid got %b exp 1", team_id_valid); else passed++;
    total++; if (err_count !== 8'd0) $display("FAIL good_errcnt got %0d exp 0", err_count); else passed++;
  endtask

  task automatic test_reset_mid;
    radio_cs_n = 0;
    repeat (4) @(negedge mclk);
    send_bits(mk(SB, 16'h5555, 8'h00), 12);
    puc_rst = 1;
    radio_cs_n = 1;
    radio_sclk = 0;
    repeat (3) @(negedge mclk);
    total++; if (team_id_out !== 16'h0000) $display("FAIL rstmid_id got %h exp 0000", team_id_out); else passed++;
    total++; if (team_id_valid !== 1'b0) $display("FAIL rstmid_valid got %b exp 0", team_id_valid); else passed++;
    total++; if (err_count !== 8'd0) $display("FAIL rstmid_errcnt got %0d exp 0", err_count); else passed++;
    puc_rst = 0;
    exp_id = 16'h0000;
    exp_valid = 0;
    exp_err = 0;
    repeat (4) @(negedge mclk);
    send_window(mk(SB, 16'h4321, 8'h62), 32, 4);
    total++; if (team_id_out !== exp_id) $display("FAIL rstmid_next_id got %h exp %h", team_id_out, exp_id); else passed++;
    total++; if (pulses !== exp_pulses) $display("FAIL rstmid_pulses got %0d exp %0d", pulses, exp_pulses); else passed++;
  endtask

  task automatic test_bad_chk;
    send_window(mk(SB, 16'h1234, 8'h26), 32, 4);
    send_window(mk(SB, 16'h1234, 8'h27), 32, 4);
    total++; if (team_id_out !== 16'h1234) $display("FAIL badchk_id got %h exp 1234", team_id_out); else passed++;
    total++; if (err_count !== 8'(exp_err)) $display("FAIL badchk_errcnt got %0d exp %0d", err_count, exp_err); else passed++;
    total++; if (pulses !== exp_pulses) $display("FAIL badchk_pulses got %0d exp %0d", pulses, exp_pulses); else passed++;
  endtask

  task automatic test_bad_sync;
    send_window({8'h5A, 16'h1234, 8'h26, SB, 16'hBEEF, 8'h51}, 64, 4);
    total++; if (team_id_out !== 16'h1234) $display("FAIL badsync_id got %h exp 1234", team_id_out); else passed++;
    total++; if (err_count !== 8'(exp_err)) $display("FAIL badsync_errcnt got %0d exp %0d", err_count, exp_err); else passed++;
    send_window(mk(SB, 16'hBEEF, 8'h51), 32, 4);
    total++; if (team_id_out !== 16'hBEEF) $display("FAIL resync_id got %h exp beef", team_id_out); else passed++;
    total++; if (pulses !== exp_pulses) $display("FAIL badsync_pulses got %0d exp %0d", pulses, exp_pulses); else passed++;
  endtask

  task automatic test_abort;
    send_window(mk(SB, 16'hCAFE, 8'h34), 20, 4);
    total++; if (err_count !== 8'(exp_err)) $display("FAIL abort_errcnt got %0d exp %0d", err_count, exp_err); else passed++;
    total++; if (team_id_out !== 16'hBEEF) $display("FAIL abort_id got %h exp beef", team_id_out); else passed++;
    send_window(mk(SB, 16'hCAFE, 8'h34), 14, 4200);
    total++; if (err_count !== 8'(exp_err)) $display("FAIL timeout_errcnt got %0d exp %0d", err_count, exp_err); else passed++;
    total++; if (pulses !== exp_pulses) $display("FAIL timeout_pulses got %0d exp %0d", pulses, exp_pulses); else passed++;
    send_window(mk(SB, 16'hCAFE, 8'h34), 32, 4);
    total++; if (team_id_out !== 16'hCAFE) $display("FAIL after_timeout_id got %h exp cafe", team_id_out); else passed++;
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] s, c;
      logic [15:0] id;
      int n;
      id = 16'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : SB;
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : id[15:8] ^ id[7:0];
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : 32;
      send_window({s, id, c, 32'($urandom)}, n, int'($urandom_range(3, 12)));
      total++; if (team_id_out !== exp_id) $display("FAIL rand%0d_id got %h exp %h", k, team_id_out, exp_id); else passed++;
      total++; if (team_id_valid !== exp_valid) $display("FAIL rand%0d_valid got %b exp %b", k, team_id_valid, exp_valid); else passed++;
      total++; if (err_count !== 8'(exp_err)) $display("FAIL rand%0d_errcnt got %0d exp %0d", k, err_count, exp_err); else passed++;
      total++; if (pulses !== exp_pulses) $display("FAIL rand%0d_pulses got %0d exp %0d", k, pulses, exp_pulses); else passed++;
    end
  endtask

  task automatic test_saturate;
    for (int k = 0; k < 300; k++) begin
      logic [63:0] b;
      int n;
      n = int'($urandom_range(0, 8));
      b = {SB ^ 8'($urandom_range(1, 255)), 56'h0};
      send_window(b, n, 3);
    end
    total++; if (err_count !== 8'd255) $display("FAIL sat_errcnt got %0d exp 255", err_count); else passed++;
    total++; if (pulses !== exp_pulses) $display("FAIL sat_pulses got %0d exp %0d", pulses, exp_pulses); else passed++;
    send_window(mk(SB, 16'h00FF, 8'hFF), 20, 4);
    total++; if (err_count !== 8'd255) $display("FAIL sat_hold_errcnt got %0d exp 255", err_count); else passed++;
    send_window(mk(SB, 16'h0F0F, 8'h00), 32, 4);
    total++; if (team_id_out !== 16'h0F0F) $display("FAIL sat_good_id got %h exp 0f0f", team_id_out); else passed++;
    total++; if (team_id_out !== exp_id) $display("FAIL sat_model_id got %h exp %h", team_id_out, exp_id); else passed++;
  endtask

  initial begin
    test_reset;
    test_good;
    test_reset_mid;
    test_bad_chk;
    test_bad_sync;
    test_abort;
    test_random;
    test_saturate;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
